screen_leds_ctrl: RTL and testbench

Parametrised front-panel controller for the screen-leds display.
- Polls push-buttons on a divided tick and debounces them.
- Converts each clean press into one increment or decrement of the displayed byte or row.
- Drives the byte/row values consumed by the leds renderer and the board debug LEDs.
- Replaces counter-bit-clocked polling with a single-clock design using a clock enable.

---
 rtl/screen_leds_pkg.sv | 16 +
 rtl/screen_leds_ctrl_if.sv | 25 ++
 rtl/btn_debounce.sv | 83 ++++++++
 rtl/screen_leds_ctrl.sv | 75 +++++++
 tb/tb_screen_leds_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/screen_leds_pkg.sv
// Shared constants and button FSM encoding for the screen-leds front-panel controller.
package screen_leds_pkg;

    localparam int unsigned DEF_BYTE_W     = 8;
    localparam int unsigned DEF_ROWS       = 6;
    localparam int unsigned DEF_ROW_W      = 4;
    localparam int unsigned DEF_ROW_INIT   = 2;
    localparam int unsigned DEF_POLL_DIV_W = 21;
    localparam int unsigned DEF_HOLD_TICKS = 4;

    typedef logic [1:0] btn_state_t;
    localparam btn_state_t IDLE    = 2'd0;
    localparam btn_state_t PRESSED = 2'd1;
    localparam btn_state_t REPEAT  = 2'd2;

endpackage

// File: rtl/screen_leds_ctrl_if.sv
// Front-panel bus: raw push-buttons in, display byte/row and debug LEDs out.
interface screen_leds_ctrl_if
    import screen_leds_pkg::*;
#(
    parameter int unsigned BYTE_W = DEF_BYTE_W,
    parameter int unsigned ROW_W  = DEF_ROW_W
);
    logic              inc_row;
    logic              inc_byte;
    logic              dec_byte;
    logic [BYTE_W-1:0] byte_led;
    logic [ROW_W-1:0]  row_led;
    logic [BYTE_W-1:0] disp;
    logic              changed;

    modport master (
        output inc_row, inc_byte, dec_byte,
        input  byte_led, row_led, disp, changed
    );

    modport slave (
        input  inc_row, inc_byte, dec_byte,
        output byte_led, row_led, disp, changed
    );
endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, tick-sampled debounce and press FSM.
// Auto-repeat (REPEAT state and hold counter) is built only with SCREEN_LEDS_AUTOREPEAT_EN.
module btn_debounce
    import screen_leds_pkg::*;
#(
`ifdef SCREEN_LEDS_AUTOREPEAT_EN
    parameter int unsigned HOLD_TICKS = DEF_HOLD_TICKS
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic pulse
);
    logic [1:0] sync;
    logic       sample_prev;
    logic       level;
    logic       level_next;
    btn_state_t state;

    // Debounced level moves only when this tick's sample matches the previous one.
    assign level_next = (sync[1] == sample_prev) ? sync[1] : level;

`ifdef SCREEN_LEDS_AUTOREPEAT_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
    logic [HOLD_W-1:0] hold_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= '0;
            sample_prev <= 1'b0;
            level       <= 1'b0;
            state       <= IDLE;
            pulse       <= 1'b0;
`ifdef SCREEN_LEDS_AUTOREPEAT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            sync  <= {sync[0], btn};
            pulse <= 1'b0;
            if (tick) begin
                sample_prev <= sync[1];
                level       <= level_next;
                case (state)
                    IDLE: begin
                        if (level_next) begin
                            state <= PRESSED;
                            pulse <= 1'b1;
`ifdef SCREEN_LEDS_AUTOREPEAT_EN
                            hold_cnt <= '0;
`endif
                        end
                    end
                    PRESSED: begin
                        if (!level_next) begin
                            state <= IDLE;
                        end
`ifdef SCREEN_LEDS_AUTOREPEAT_EN
                        else if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                            state <= REPEAT;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
`endif
                    end
`ifdef SCREEN_LEDS_AUTOREPEAT_EN
                    REPEAT: begin
                        if (!level_next) begin
                            state <= IDLE;
                        end else begin
                            pulse <= 1'b1;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/screen_leds_ctrl.sv
// Front-panel controller: poll divider, three debounced buttons, byte/row counters.
// Define SCREEN_LEDS_AUTOREPEAT_EN to enable auto-repeat on held buttons.
module screen_leds_ctrl
    import screen_leds_pkg::*;
#(
    parameter int unsigned BYTE_W     = DEF_BYTE_W,
    parameter int unsigned ROWS       = DEF_ROWS,
    parameter int unsigned ROW_W      = DEF_ROW_W,
    parameter int unsigned ROW_INIT   = DEF_ROW_INIT,
    parameter int unsigned POLL_DIV_W = DEF_POLL_DIV_W,
    parameter int unsigned HOLD_TICKS = DEF_HOLD_TICKS
) (
    input logic              clk,
    input logic              rst_n,
    screen_leds_ctrl_if.slave bus
);
    if ((1 << ROW_W) < ROWS || ROW_INIT >= ROWS || HOLD_TICKS == 0) begin : g_bad_params
        $error("screen_leds_ctrl: inconsistent ROWS/ROW_W/ROW_INIT/HOLD_TICKS");
    end

    logic [POLL_DIV_W-1:0] div;
    logic                  tick;
    logic [2:0]            raw;
    logic [2:0]            ev;
    logic [BYTE_W-1:0]     byte_q;
    logic [ROW_W-1:0]      row_q;
    logic                  changed_q;

    assign tick = &div;
    assign raw  = {bus.inc_row, bus.inc_byte, bus.dec_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div <= '0;
        else        div <= div + 1'b1;
    end

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debounce
`ifdef SCREEN_LEDS_AUTOREPEAT_EN
            #(.HOLD_TICKS(HOLD_TICKS))
`endif
        u_btn (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .btn   (raw[i]),
            .pulse (ev[i])
        );
    end

    // Opposing byte events cancel; a row event still counts as a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q    <= '0;
            row_q     <= ROW_W'(ROW_INIT);
            changed_q <= 1'b0;
        end else begin
            changed_q <= ev[2] | (ev[1] ^ ev[0]);
            if (ev[2]) begin
                row_q <= (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
            end
            if (ev[1] && !ev[0]) begin
                byte_q <= byte_q + 1'b1;
            end else if (ev[0] && !ev[1]) begin
                byte_q <= byte_q - 1'b1;
            end
        end
    end

    assign bus.byte_led = byte_q;
    assign bus.disp     = byte_q;
    assign bus.row_led  = row_q;
    assign bus.changed  = changed_q;

endmodule

// File: tb/tb_screen_leds_ctrl.sv
// Bench for screen_leds_ctrl: tick-level reference model, vector table and corner sequences.
module tb_screen_leds_ctrl;

    localparam int unsigned TICK = 16;
    localparam int unsigned HOLD = 2;
    localparam int unsigned NROW = 6;
`ifdef SCREEN_LEDS_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    screen_leds_ctrl_if #(.BYTE_W(8), .ROW_W(4)) bus ();

    screen_leds_ctrl #(
        .BYTE_W     (8),
        .ROWS       (6),
        .ROW_W      (4),
        .ROW_INIT   (2),
        .POLL_DIV_W (4),
        .HOLD_TICKS (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned tests_run = 0;
    int unsigned failed    = 0;

    // Reference model state; button vectors are {inc_row, inc_byte, dec_byte}.
    int unsigned n;
    logic [2:0]  hist[$];
    logic [2:0]  prev_s;
    logic [2:0]  deb;
    int          held[3];
    logic [2:0]  pend;
    logic [7:0]  exp_byte;
    int          exp_row;
    logic        exp_chg;
    int unsigned chg_seen;
    int unsigned exp_pulses;

    typedef struct {
        logic [2:0] btn;
        logic [7:0] exp_byte;
        logic [3:0] exp_row;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input longint act, input longint exp);
        tests_run++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        hist.delete();
        prev_s = '0;
        deb = '0;
        for (int b = 0; b < 3; b++) held[b] = -1;
        pend = '0;
        exp_byte = 8'd0;
        exp_row = 2;
        exp_chg = 1'b0;
    endtask

    // One rising edge: apply last tick's events, then take a tick sample if due.
    task automatic model_edge();
        logic [2:0] s;
        logic       nd;
        exp_chg = 1'b0;
        if (pend[2]) exp_row = (exp_row + 1) % NROW;
        if (pend[1] && !pend[0]) exp_byte = exp_byte + 8'd1;
        if (pend[0] && !pend[1]) exp_byte = exp_byte - 8'd1;
        exp_chg = pend[2] | (pend[1] ^ pend[0]);
        pend = '0;
        n++;
        if (n % TICK == 0) begin
            s = hist[n-3];
            for (int b = 0; b < 3; b++) begin
                nd = (s[b] == prev_s[b]) ? s[b] : deb[b];
                prev_s[b] = s[b];
                if (nd) begin
                    held[b] = deb[b] ? held[b] + 1 : 0;
                    pend[b] = (held[b] == 0) || (AR && held[b] > int'(HOLD));
                end else begin
                    held[b] = -1;
                end
                deb[b] = nd;
            end
        end
        if (exp_chg) exp_pulses++;
    endtask

    task automatic step(input logic [2:0] btn);
        bus.inc_row  = btn[2];
        bus.inc_byte = btn[1];
        bus.dec_byte = btn[0];
        hist.push_back(btn);
        @(posedge clk);
        #1;
        model_edge();
        if (bus.changed) chg_seen++;
        check("byte_led", bus.byte_led, exp_byte);
        check("row_led",  bus.row_led,  exp_row);
        check("changed",  bus.changed,  exp_chg);
        check("disp",     bus.disp,     exp_byte);
    endtask

    task automatic press(input logic [2:0] btn, input int unsigned on, input int unsigned off);
        repeat (on)  step(btn);
        repeat (off) step(3'b000);
    endtask

    task automatic do_reset(input logic [2:0] btn);
        rst_n = 1'b0;
        bus.inc_row  = btn[2];
        bus.inc_byte = btn[1];
        bus.dec_byte = btn[0];
        #1;
        check("rst_byte",    bus.byte_led, 0);
        check("rst_row",     bus.row_led,  2);
        check("rst_changed", bus.changed,  0);
        check("rst_disp",    bus.disp,     0);
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{3'b010, 8'd1,   4'd2};
        tbl[1]  = '{3'b010, 8'd2,   4'd2};
        tbl[2]  = '{3'b001, 8'd1,   4'd2};
        tbl[3]  = '{3'b100, 8'd1,   4'd3};
        tbl[4]  = '{3'b110, 8'd2,   4'd4};
        tbl[5]  = '{3'b011, 8'd2,   4'd4};
        tbl[6]  = '{3'b100, 8'd2,   4'd5};
        tbl[7]  = '{3'b100, 8'd2,   4'd0};
        tbl[8]  = '{3'b001, 8'd1,   4'd0};
        tbl[9]  = '{3'b001, 8'd0,   4'd0};
        tbl[10] = '{3'b001, 8'hFF,  4'd0};
        tbl[11] = '{3'b010, 8'h00,  4'd0};
        tbl[12] = '{3'b111, 8'h00,  4'd1};

        bus.inc_row = 1'b0; bus.inc_byte = 1'b0; bus.dec_byte = 1'b0;
        chg_seen = 0; exp_pulses = 0;
        #2;

        // Idle after reset
        do_reset(3'b000);
        repeat (100) step(3'b000);
        check("idle_pulses", chg_seen, 0);

        // Single long press
        chg_seen = 0; exp_pulses = 0;
        press(3'b010, 80, 64);
        check("single_pulses_vs_model", chg_seen, exp_pulses);
`ifndef SCREEN_LEDS_AUTOREPEAT_EN
        check("single_byte", bus.byte_led, 1);
        check("single_pulse_count", chg_seen, 1);
`endif

        // Bounce phased so no two consecutive samples agree high
        do_reset(3'b000);
        for (int i = 0; i < 32 && (n % TICK) != 1; i++) step(3'b000);
        chg_seen = 0;
        for (int k = 0; k < 40; k++) step(((k / 3) % 2 == 0) ? 3'b010 : 3'b000);
        repeat (64) step(3'b000);
        check("bounce_byte", bus.byte_led, 0);
        check("bounce_pulses", chg_seen, 0);

        // Vector table
        do_reset(3'b000);
        for (int i = 0; i < 13; i++) begin
            press(tbl[i].btn, 40, 64);
            check($sformatf("tbl%0d_byte", i), bus.byte_led, tbl[i].exp_byte);
            check($sformatf("tbl%0d_row", i),  bus.row_led,  tbl[i].exp_row);
        end

        // Simultaneous inc/dec, then row alone
        chg_seen = 0;
        press(3'b011, 40, 64);
        check("simul_byte", bus.byte_led, 0);
        check("simul_pulses", chg_seen, 0);
        press(3'b100, 40, 64);
        check("simul_row", bus.row_led, 2);

        // Wrap via preload
        do_reset(3'b000);
        repeat (255) press(3'b010, 40, 40);
        check("preload_ff", bus.byte_led, 8'hFF);
        press(3'b010, 40, 64);
        check("wrap_up", bus.byte_led, 8'h00);
        press(3'b001, 40, 64);
        check("wrap_down", bus.byte_led, 8'hFF);
        repeat (3) press(3'b100, 40, 64);
        check("row_five", bus.row_led, 5);
        press(3'b100, 40, 64);
        check("row_wrap", bus.row_led, 0);

        // Reset while the button is held
        do_reset(3'b000);
        repeat (40) step(3'b010);
        check("midrst_before", bus.byte_led, 1);
        do_reset(3'b010);
        repeat (40) step(3'b010);
        repeat (64) step(3'b000);
        check("midrst_after", bus.byte_led, 1);

`ifdef SCREEN_LEDS_AUTOREPEAT_EN
        // Eight tick samples high
        do_reset(3'b000);
        for (int i = 0; i < 32 && (n % TICK) != 14; i++) step(3'b000);
        press(3'b010, 128, 64);
        check("ar_hold8_byte", bus.byte_led, 6);
        repeat (64) step(3'b010);
        do_reset(3'b010);
        check("ar_rst_byte", bus.byte_led, 0);
        press(3'b010, 40, 64);
        check("ar_redebounce", bus.byte_led, 1);
`endif

        // Randomized presses against the model
        do_reset(3'b000);
        for (int i = 0; i < 60; i++) begin
            press(3'($urandom_range(0, 7)), $urandom_range(1, 80), $urandom_range(1, 60));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
